// File: rtl/spreading_factors_pkg.sv
// spreading_factors_pkg: DCSK spreading factor encoding shared with the transmitter.
package spreading_factors_pkg;
    typedef enum logic [1:0] {SF2, SF4, SF8, SF16} sf_t;
endpackage

// File: rtl/tx_sched_pkg.sv
// tx_sched_pkg: scheduler state encoding and expected chip count per message.
package tx_sched_pkg;
    import spreading_factors_pkg::*;
    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_START, ACTIVE} sched_state_t;
    localparam int CHIPS_PER_BIT_BASE = 2;
    localparam int MSG_BITS = 32;
    // Reference + data half-frames per bit, each 2^(sf+1) chips long.
    function automatic logic [10:0] expected_chips(input sf_t sf);
        return 11'(MSG_BITS * CHIPS_PER_BIT_BASE) << (int'(sf) + 1);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, search starting at ptr and wrapping modulo N.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 any
);
    localparam int IW = $clog2(N);
    logic [IW-1:0] idx;
    always_comb begin
        gnt = '0;
        gnt_id = '0;
        any = 1'b0;
        idx = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr) + k) % N);
            if (en && !any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id = idx;
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/dcsk_tx_scheduler.sv
// dcsk_tx_scheduler: round-robin sharing of one DCSK tx between N requesters with seed reloads and supervision.
// Define DCSK_TX_SCHED_LEN_CHECK_EN to enable the chip-count check driving o_err_len.
module dcsk_tx_scheduler
    import spreading_factors_pkg::*, tx_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int START_TIMEOUT = 16,
    parameter int SEED_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_arst_n,
    input  logic [N_REQ-1:0]         i_req_valid,
    output logic [N_REQ-1:0]         o_req_ready,
    input  logic [N_REQ-1:0][31:0]   i_req_msg,
    input  logic [N_REQ-1:0][1:0]    i_req_sf,
    input  logic [SEED_W-1:0]        i_seed,
    input  logic                     i_seed_update,
    output logic [SEED_W-1:0]        o_seed,
    output logic                     o_load_seed,
    output logic                     o_send,
    output logic [31:0]              o_msg,
    output logic [1:0]               o_sf,
    input  logic                     i_is_sending,
    output logic                     o_busy,
    output logic [$clog2(N_REQ)-1:0] o_grant_id,
    output logic                     o_err_timeout,
    output logic                     o_err_len
);
    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(START_TIMEOUT + 1);
    sched_state_t state;
    logic [IW-1:0] rr_ptr, gnt_id;
    logic [N_REQ-1:0] gnt;
    logic gnt_any, seed_pending, arb_en;
    logic [TW-1:0] timer;
    assign arb_en = state == IDLE && !seed_pending;
    assign o_req_ready = gnt;
    assign o_busy = state != IDLE;
    rr_arbiter #(.N(N_REQ)) u_arb (
        .req(i_req_valid), .ptr(rr_ptr), .en(arb_en),
        .gnt(gnt), .gnt_id(gnt_id), .any(gnt_any)
    );
    // Newest seed wins; a pulse landing during LOAD keeps the reload pending.
    always_ff @(posedge i_clk or negedge i_arst_n)
        if (!i_arst_n) begin
            o_seed <= '0;
            seed_pending <= 1'b0;
        end else if (i_seed_update) begin
            o_seed <= i_seed;
            seed_pending <= 1'b1;
        end else if (state == LOAD) seed_pending <= 1'b0;
    always_ff @(posedge i_clk or negedge i_arst_n)
        if (!i_arst_n) begin
            state <= IDLE;
            rr_ptr <= '0;
            timer <= '0;
            o_send <= 1'b0;
            o_load_seed <= 1'b0;
            o_err_timeout <= 1'b0;
            o_msg <= '0;
            o_sf <= '0;
            o_grant_id <= '0;
        end else begin
            o_send <= 1'b0;
            o_load_seed <= 1'b0;
            o_err_timeout <= 1'b0;
            case (state)
                IDLE:
                    if (seed_pending) begin
                        state <= LOAD;
                        o_load_seed <= 1'b1;
                    end else if (gnt_any) begin
                        state <= SEND;
                        o_send <= 1'b1;
                        o_msg <= i_req_msg[gnt_id];
                        o_sf <= i_req_sf[gnt_id];
                        o_grant_id <= gnt_id;
                        rr_ptr <= gnt_id == IW'(N_REQ - 1) ? '0 : gnt_id + 1'b1;
                    end
                LOAD: state <= IDLE;
                SEND: begin
                    state <= WAIT_START;
                    timer <= TW'(1);  // counts cycles since o_send
                end
                WAIT_START:
                    if (i_is_sending) state <= ACTIVE;
                    else if (timer == TW'(START_TIMEOUT - 1)) begin
                        o_err_timeout <= 1'b1;
                        state <= IDLE;
                    end else timer <= timer + 1'b1;
                ACTIVE: if (!i_is_sending) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
`ifdef DCSK_TX_SCHED_LEN_CHECK_EN
    logic [10:0] chip_cnt;
    always_ff @(posedge i_clk or negedge i_arst_n)
        if (!i_arst_n) begin
            chip_cnt <= '0;
            o_err_len <= 1'b0;
        end else begin
            o_err_len <= 1'b0;
            if (state == WAIT_START && i_is_sending) chip_cnt <= 11'd1;
            else if (state == ACTIVE && i_is_sending) chip_cnt <= chip_cnt + {10'd0, chip_cnt != '1};
            else if (state == ACTIVE) o_err_len <= chip_cnt != expected_chips(sf_t'(o_sf));
        end
`else
    assign o_err_len = 1'b0;
`endif
endmodule

// File: tb/tb_dcsk_tx_scheduler.sv
// tb_dcsk_tx_scheduler: directed checks of arbitration, seed reload, timeout, length check and reset.
module tb_dcsk_tx_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] valid = '0, ready;
    logic [3:0][31:0] req_msg = '0;
    logic [3:0][1:0] req_sf = '0;
    logic [7:0] seed_in = '0, seed;
    logic seed_update = 1'b0, load_seed, send, is_sending = 1'b0, busy, err_timeout, err_len;
    logic [31:0] msg;
    logic [1:0] sf, gid;
    int errors = 0, checks = 0;
`ifdef DCSK_TX_SCHED_LEN_CHECK_EN
    localparam logic EXP_LEN_ERR = 1'b1;
`else
    localparam logic EXP_LEN_ERR = 1'b0;
`endif
    dcsk_tx_scheduler dut (
        .i_clk(clk), .i_arst_n(rst_n), .i_req_valid(valid), .o_req_ready(ready),
        .i_req_msg(req_msg), .i_req_sf(req_sf), .i_seed(seed_in), .i_seed_update(seed_update),
        .o_seed(seed), .o_load_seed(load_seed), .o_send(send), .o_msg(msg), .o_sf(sf),
        .i_is_sending(is_sending), .o_busy(busy), .o_grant_id(gid),
        .o_err_timeout(err_timeout), .o_err_len(err_len)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    // One granted message with a stub tx asserting is_sending for len cycles.
    task automatic serve(input int id, input int len);
        chk("rr_ready", ready, 1 << id);
        tick();
        chk("rr_send", send, 1);
        chk("rr_gid", gid, id);
        chk("rr_msg", msg, req_msg[id[1:0]]);
        tick();
        is_sending = 1'b1;
        tick(len);
        is_sending = 1'b0;
        tick();
        chk("rr_idle", busy, 0);
        chk("rr_err_len", err_len, 0);
    endtask
    initial begin
        tick(2);
        chk("rst_busy", busy, 0);
        chk("rst_send", send, 0);
        chk("rst_load", load_seed, 0);
        chk("rst_seed", seed, 0);
        chk("rst_msg", msg, 0);
        chk("rst_gid", gid, 0);
        chk("rst_errs", {err_timeout, err_len}, 0);
        rst_n = 1'b1;
        tick();
        // single request, SF4 -> 256 chips
        valid = 4'b0001;
        req_msg[0] = 32'hDEADBEEF;
        req_sf[0] = 2'd1;
        #1;
        chk("t1_ready", ready, 4'b0001);
        tick();
        chk("t1_send", send, 1);
        chk("t1_msg", msg, 32'hDEADBEEF);
        chk("t1_sf", sf, 1);
        chk("t1_gid", gid, 0);
        chk("t1_busy", busy, 1);
        valid = '0;
        #1;
        chk("t1_ready_off", ready, 0);
        tick();
        chk("t1_send_1cyc", send, 0);
        is_sending = 1'b1;
        tick(100);
        chk("t1_msg_hold", msg, 32'hDEADBEEF);
        tick(156);
        is_sending = 1'b0;
        tick();
        chk("t1_idle", busy, 0);
        chk("t1_err_len", err_len, 0);
        chk("t1_err_to", err_timeout, 0);
        // all requesters, SF2; pointer sits at 1 after the first grant
        for (int i = 0; i < 4; i++) begin
            req_msg[i] = 32'hA000_0000 + i;
            req_sf[i] = 2'd0;
        end
        valid = 4'b1111;
        #1;
        serve(1, 128);
        serve(2, 128);
        serve(3, 128);
        serve(0, 128);
        serve(1, 128);
        valid = '0;
        // seed update during an SF8 message from requester 2
        valid = 4'b0100;
        req_sf[2] = 2'd2;
        req_msg[2] = 32'h5EED_0002;
        #1;
        chk("t3_seed_pre", seed, 0);
        chk("t3_ready", ready, 4'b0100);
        tick();
        chk("t3_send", send, 1);
        tick();
        is_sending = 1'b1;
        tick(200);
        seed_in = 8'hFB;
        seed_update = 1'b1;
        tick();
        seed_update = 1'b0;
        chk("t3_seed_cap", seed, 8'hFB);
        chk("t3_no_load_busy", load_seed, 0);
        tick(311);
        is_sending = 1'b0;
        tick();
        chk("t3_idle", busy, 0);
        chk("t3_seed_first", ready, 0);
        chk("t3_err_len", err_len, 0);
        tick();
        chk("t3_load", load_seed, 1);
        chk("t3_load_seed", seed, 8'hFB);
        chk("t3_no_send", send, 0);
        tick();
        chk("t3_load_1cyc", load_seed, 0);
        chk("t3_ready_after", ready, 4'b0100);
        tick();
        chk("t3_send2", send, 1);
        chk("t3_gid2", gid, 2);
        // tx never starts: timeout 16 cycles after o_send
        valid = 4'b1100;
        tick(15);
        chk("t4_no_to_early", err_timeout, 0);
        chk("t4_busy", busy, 1);
        tick();
        chk("t4_timeout", err_timeout, 1);
        chk("t4_idle", busy, 0);
        chk("t4_next_ready", ready, 4'b1000);
        tick();
        chk("t4_to_1cyc", err_timeout, 0);
        chk("t4_send3", send, 1);
        chk("t4_gid3", gid, 3);
        valid = '0;
        // short message: 100 chips at SF2
        tick();
        is_sending = 1'b1;
        tick(100);
        is_sending = 1'b0;
        tick();
        chk("t5_err_len", err_len, EXP_LEN_ERR);
        chk("t5_idle", busy, 0);
        tick();
        chk("t5_err_len_1cyc", err_len, 0);
        // async reset in ACTIVE
        valid = 4'b0010;
        #1;
        tick();
        chk("t6_gid", gid, 1);
        valid = '0;
        tick();
        is_sending = 1'b1;
        tick(20);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_msg", msg, 0);
        chk("t6_rst_gid", gid, 0);
        chk("t6_rst_seed", seed, 0);
        chk("t6_rst_ready", ready, 0);
        is_sending = 1'b0;
        tick();
        rst_n = 1'b1;
        valid = 4'b0011;
        #1;
        chk("t6_ready0", ready, 4'b0001);
        tick();
        chk("t6_send", send, 1);
        chk("t6_gid0", gid, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dcsk_tx_scheduler.md
Name: dcsk_tx_scheduler

Overview:
- Sequences the DCSK transmitter (`tx`) and shares it between N message requesters.
- Arbitration is round-robin; each requester supplies a 32-bit message plus spreading factor.
- Pending seed reloads are applied only between messages.
- Each transmission is supervised: start timeout, and chip-count check on `is_sending`.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- START_TIMEOUT, 16, max cycles from `o_send` to `is_sending` rising before abort.
- SEED_W, 8, chaotic-generator seed width.

Ports:
- i_clk  in  1  system clock.
- i_arst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  N_REQ  per-requester message valid.
- o_req_ready  out  N_REQ  one-hot accept; transfer when valid&ready.
- i_req_msg  in  N_REQ x 32  per-requester message.
- i_req_sf  in  N_REQ x 2  per-requester sf_t (SF2/SF4/SF8/SF16).
- i_seed  in  SEED_W  new seed value.
- i_seed_update  in  1  pulse; requests a seed reload.
- o_seed  out  SEED_W  to tx i_seed.
- o_load_seed  out  1  to tx i_load_seed.
- o_send  out  1  to tx i_send.
- o_msg  out  32  to tx i_msg.
- o_sf  out  2  to tx i_sf.
- i_is_sending  in  1  from tx is_sending.
- o_busy  out  1  state != IDLE.
- o_grant_id  out  $clog2(N_REQ)  requester owning the current transfer.
- o_err_timeout  out  1  one-cycle pulse on start timeout.
- o_err_len  out  1  one-cycle pulse on chip-count mismatch.

Behaviour:
- Reset (async, immediate) values:
  - All outputs 0; state IDLE.
  - RR pointer 0, so requester 0 has first priority.
  - seed_pending 0; o_seed = 0.
- i_seed_update: captures i_seed into o_seed and sets seed_pending. A later pulse overwrites the value; the newest seed wins.
- FSM states: IDLE, LOAD, SEND, WAIT_START, ACTIVE.
- IDLE, seed pending:
  - Seed has priority over requests. Next state LOAD; o_req_ready = 0.
- IDLE, no seed pending, any valid:
  - o_req_ready is combinational: one-hot grant from the round-robin arbiter.
  - Search order starts at last_grant+1, wrapping modulo N_REQ.
  - On transfer, latch msg/sf into o_msg/o_sf and latch id into o_grant_id; last_grant <= id; next state SEND.
- LOAD: o_load_seed = 1 for exactly 1 cycle; clear seed_pending; next state IDLE.
- SEND: o_send = 1 for exactly 1 cycle; clear the timer; next state WAIT_START.
- WAIT_START:
  - is_sending = 1: go to ACTIVE, chip counter = 1.
  - Timer reaches START_TIMEOUT: pulse o_err_timeout and go to IDLE; the message is dropped.
- ACTIVE:
  - Chip counter increments every cycle while is_sending = 1.
  - On the cycle is_sending = 0: compare the count with expected = 64 * 2^(sf+1) (SF2=128 … SF16=1024). Counter is 11 bits.
  - Mismatch (early or late deassertion): pulse o_err_len.
  - Either way, go to IDLE.
- o_msg/o_sf are stable from SEND until IDLE is re-entered.
- i_seed_update while busy is deferred; it is applied in the next IDLE, before the next grant.
- Simultaneous i_seed_update and i_req_valid in IDLE with seed_pending = 0: that cycle's grant proceeds; the seed is applied after that message.
- A requester dropping valid without ready is legal; no state is kept for it.
- Latency from valid to o_send is 2 cycles (IDLE accept, SEND).
- Back-to-back messages: IDLE is re-entered one cycle after is_sending falls.

Optional Feature:
- Macro: DCSK_TX_SCHED_LEN_CHECK_EN.
- Defined: chip counter and length compare present, o_err_len driven.
- Undefined: no counter; o_err_len tied 0; ACTIVE exits on is_sending falling only.

Decomposition:
- Shared package tx_sched_pkg holds:
  - sched_state_t enum;
  - CHIPS_PER_BIT_BASE = 2 and MSG_BITS = 32;
  - function expected_chips(sf_t).
  - sf_t is reused from spreading_factors_pkg.
- One sub-module, rr_arbiter, parameterised N:
  - inputs req[N], ptr, en;
  - outputs one-hot gnt, gnt_id, any.

Test Plan:
- Single request, req0, msg 0xDEADBEEF, SF4: o_send pulses 2 cycles after valid; o_msg = 0xDEADBEEF held; no errors; the tx bench demod equals 0xDEADBEEF.
- All 4 requesters valid continuously: grants 0,1,2,3,0,… with no repeats while others wait; each grant follows the previous is_sending fall by 1 cycle.
- i_seed_update with 0xFB during an active SF8 message: o_load_seed pulses once with o_seed = 0xFB after is_sending falls and before the next o_send.
- Stub tx that never asserts is_sending: o_err_timeout pulses exactly START_TIMEOUT (16) cycles after o_send; the FSM returns to IDLE and serves the next requester.
- Stub drops is_sending after 100 chips with SF2 (expected 128): o_err_len pulses for 1 cycle. With the macro undefined, o_err_len stays 0.
- Assert i_arst_n low mid-ACTIVE: all outputs 0 immediately; after release, requester 0 wins the first arbitration.
